// File: rtl/pspin_her_pkg.sv
// Shared definitions for the HER generator configuration path: sequencer state
// encoding, execution-context sizing and a small handshake helper.
package pspin_her_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } conf_state_e;

  localparam int unsigned HER_NUM_HANDLER_CTX = 8;
  localparam int unsigned CTX_ID_WIDTH =
    (HER_NUM_HANDLER_CTX > 1) ? $clog2(HER_NUM_HANDLER_CTX) : 1;

  // A beat is stalled when it is offered but the receiver is not taking it.
  function automatic logic stream_stalled(input logic valid, input logic ready);
    return valid & ~ready;
  endfunction

endpackage

// File: rtl/pspin_her_conf_seq_if.sv
// Completion stream (ingress DMA -> HER generator), observed HER handshake and
// PsPIN handler-completion feedback, bundled for the configuration sequencer.
interface pspin_her_conf_seq_if;

  logic up_valid;
  logic up_ready;
  logic dn_valid;
  logic dn_ready;
  logic her_valid;
  logic her_ready;
  logic fb_valid;

  // Environment side: ingress DMA, HER generator and PsPIN.
  modport master (
    output up_valid, dn_ready, her_valid, her_ready, fb_valid,
    input  up_ready, dn_valid
  );

  // Sequencer side.
  modport slave (
    input  up_valid, dn_ready, her_valid, her_ready, fb_valid,
    output up_ready, dn_valid
  );

endinterface

// File: rtl/pspin_sat_updown_cnt.sv
// Saturating up/down counter with a sticky underflow flag. Simultaneous up and
// down requests cancel; counting up at the maximum holds, counting down at zero
// holds at zero and raises the flag until reset.
module pspin_sat_updown_cnt #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             underflow_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             uf_q, uf_d;

  // Next count: cancel opposing requests, saturate at both ends.
  always_comb begin
    cnt_d = cnt_q;
    uf_d  = uf_q;
    if (inc_i && !dec_i) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) begin
        uf_d = 1'b1;
      end else begin
        cnt_d = cnt_q - WIDTH'(1);
      end
    end
  end

  // Count and sticky flag registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign underflow_o = uf_q;

endmodule

// File: rtl/pspin_her_conf_seq.sv
// Context reconfiguration sequencer for the HER generator. A host request
// stalls new completions, waits for all in-flight HERs to be retired by PsPIN,
// then strobes the generator's config latch for one cycle. A drain that takes
// too long is abandoned and reported without applying the config.
module pspin_her_conf_seq
  import pspin_her_pkg::*;
#(
  parameter int unsigned               INFLIGHT_WIDTH = 16,
  parameter int unsigned               TIMEOUT_WIDTH  = 24,
  parameter logic [TIMEOUT_WIDTH-1:0]  DRAIN_TIMEOUT  = 24'd1000000
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      conf_req,
  output logic                      conf_valid,
  output logic                      conf_busy,
  output logic                      conf_done,
  output logic                      conf_err,
  pspin_her_conf_seq_if.slave       bus,
  output logic [INFLIGHT_WIDTH-1:0] inflight,
  output logic                      underflow_err
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = DRAIN_TIMEOUT - TIMEOUT_WIDTH'(1);
  localparam bit                       TIMEOUT_EN   = (DRAIN_TIMEOUT != '0);

  conf_state_e              state_q, state_d;
  logic                     gate_q, gate_d;
  logic                     req_pending_q, req_pending_d;
  logic                     conf_valid_q, conf_valid_d;
  logic                     conf_done_q, conf_done_d;
  logic                     conf_err_q, conf_err_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                     req_clear;
  logic                     her_fire;
  logic                     dn_stalled;

  // Completions pass straight through unless a sequence is holding them back.
  assign bus.dn_valid = bus.up_valid & ~gate_q;
  assign bus.up_ready = bus.dn_ready & ~gate_q;

  assign her_fire   = bus.her_valid & bus.her_ready;
  assign dn_stalled = stream_stalled(bus.dn_valid, bus.dn_ready);

  // HERs issued minus handler completions; keeps counting in every state so
  // HERs accepted just before gating are still waited for.
  pspin_sat_updown_cnt #(
    .WIDTH (INFLIGHT_WIDTH)
  ) u_inflight_cnt (
    .clk         (clk),
    .rstn        (rstn),
    .inc_i       (her_fire),
    .dec_i       (bus.fb_valid),
    .cnt_o       (inflight),
    .underflow_o (underflow_err)
  );

  // Sequencer next state: wait for a request without breaking an offered beat,
  // drain to zero (or time out), then apply for exactly one cycle.
  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    req_clear    = 1'b0;
    conf_done_d  = 1'b0;
    conf_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_pending_q && !dn_stalled) begin
          state_d   = DRAIN;
          tmo_cnt_d = '0;
          req_clear = 1'b1;
        end
      end
      DRAIN: begin
        if (inflight == '0) begin
          state_d = APPLY;
        end else if (TIMEOUT_EN && (tmo_cnt_q == TIMEOUT_LAST)) begin
          state_d     = IDLE;
          conf_done_d = 1'b1;
          conf_err_d  = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TIMEOUT_WIDTH'(1);
        end
      end
      APPLY: begin
        state_d     = IDLE;
        conf_done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    conf_valid_d  = (state_d == APPLY);
    gate_d        = (state_d == DRAIN) || (state_d == APPLY);
    // A new request always wins so one arriving mid-sequence is never lost;
    // repeated requests before service collapse into one.
    req_pending_d = conf_req | (req_pending_q & ~req_clear);
  end

  // Sequencer registers; reset discards any pending request and staged apply.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      gate_q        <= 1'b0;
      req_pending_q <= 1'b0;
      conf_valid_q  <= 1'b0;
      conf_done_q   <= 1'b0;
      conf_err_q    <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      gate_q        <= gate_d;
      req_pending_q <= req_pending_d;
      conf_valid_q  <= conf_valid_d;
      conf_done_q   <= conf_done_d;
      conf_err_q    <= conf_err_d;
      tmo_cnt_q     <= tmo_cnt_d;
    end
  end

  assign conf_valid = conf_valid_q;
  assign conf_done  = conf_done_q;
  assign conf_err   = conf_err_q;
  assign conf_busy  = req_pending_q | (state_q != IDLE);

endmodule

// File: tb/tb_pspin_her_conf_seq.sv
// Randomized bench for the HER configuration sequencer. A behavioural model
// tracks requests, drain progress and the in-flight count; expected outputs are
// queued per cycle and per finished sequence and checked by a separate monitor.
module tb_pspin_her_conf_seq;

  localparam int IW      = 4;
  localparam int TO      = 100;
  localparam int INF_MAX = (1 << IW) - 1;
  localparam int NCYC    = 2400;

  localparam int SEQ_WAIT  = 0;
  localparam int SEQ_DRAIN = 1;
  localparam int SEQ_APPLY = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          conf_req;
  logic          conf_valid;
  logic          conf_busy;
  logic          conf_done;
  logic          conf_err;
  logic [IW-1:0] inflight;
  logic          underflow_err;

  pspin_her_conf_seq_if bus ();

  pspin_her_conf_seq #(
    .INFLIGHT_WIDTH (IW),
    .TIMEOUT_WIDTH  (24),
    .DRAIN_TIMEOUT  (24'd100)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .conf_req      (conf_req),
    .conf_valid    (conf_valid),
    .conf_busy     (conf_busy),
    .conf_done     (conf_done),
    .conf_err      (conf_err),
    .bus           (bus),
    .inflight      (inflight),
    .underflow_err (underflow_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic upReady;
    logic dnValid;
    logic confValid;
    logic confDone;
    logic confErr;
    logic confBusy;
    logic underflow;
    int   inflight;
  } snap_t;

  snap_t snapQ[$];
  bit    doneQ[$];
  int    checks = 0;
  int    errors = 0;
  bit    monitorOn = 1'b0;
  snap_t monSnap;

  // Reference model state, in terms of the behaviour rather than the RTL.
  int mInflight;
  bit mUnder;
  bit mPending;
  int mPhase;
  int mDrainAge;
  bit mDonePulse;
  bit mErrPulse;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int mode);
    conf_req     = ($urandom_range(0, 19) == 0);
    bus.up_valid = $urandom_range(0, 1);
    bus.dn_ready = ($urandom_range(0, 2) != 0);
    case (mode)
      0: begin
        bus.her_valid = ($urandom_range(0, 2) == 0);
        bus.her_ready = $urandom_range(0, 1);
        bus.fb_valid  = ($urandom_range(0, 3) == 0);
      end
      1: begin
        bus.her_valid = ($urandom_range(0, 5) == 0);
        bus.her_ready = 1'b1;
        bus.fb_valid  = 1'b0;
      end
      2: begin
        bus.her_valid = ($urandom_range(0, 7) != 0);
        bus.her_ready = 1'b1;
        bus.fb_valid  = ($urandom_range(0, 15) == 0);
      end
      default: begin
        bus.her_valid = ($urandom_range(0, 9) == 0);
        bus.her_ready = 1'b1;
        bus.fb_valid  = ($urandom_range(0, 1) == 1);
      end
    endcase
    rstn = ($urandom_range(0, 399) != 0);
  endtask

  task automatic modelReset();
    mInflight  = 0;
    mUnder     = 1'b0;
    mPending   = 1'b0;
    mPhase     = SEQ_WAIT;
    mDrainAge  = 0;
    mDonePulse = 1'b0;
    mErrPulse  = 1'b0;
  endtask

  task automatic pushSnapshot();
    snap_t s;
    bit    gated;
    gated       = (mPhase != SEQ_WAIT);
    s.upReady   = bus.dn_ready && !gated;
    s.dnValid   = bus.up_valid && !gated;
    s.confValid = (mPhase == SEQ_APPLY);
    s.confDone  = mDonePulse;
    s.confErr   = mErrPulse;
    s.confBusy  = mPending || gated;
    s.underflow = mUnder;
    s.inflight  = mInflight;
    snapQ.push_back(s);
  endtask

  task automatic modelAdvance();
    bit herFire;
    bit fb;
    bit wasEmpty;
    bit taken;
    if (!rstn) begin
      modelReset();
      return;
    end
    herFire    = bus.her_valid && bus.her_ready;
    fb         = bus.fb_valid;
    wasEmpty   = (mInflight == 0);
    taken      = 1'b0;
    mDonePulse = 1'b0;
    mErrPulse  = 1'b0;
    if (herFire && !fb) begin
      mInflight = (mInflight >= INF_MAX) ? INF_MAX : mInflight + 1;
    end else if (fb && !herFire) begin
      if (mInflight == 0) mUnder = 1'b1;
      else mInflight = mInflight - 1;
    end
    if (mPhase == SEQ_WAIT) begin
      if (mPending && !(bus.up_valid && !bus.dn_ready)) begin
        mPhase    = SEQ_DRAIN;
        mDrainAge = 0;
        taken     = 1'b1;
      end
    end else if (mPhase == SEQ_DRAIN) begin
      if (wasEmpty) begin
        mPhase = SEQ_APPLY;
      end else if (mDrainAge == TO - 1) begin
        mPhase     = SEQ_WAIT;
        mDonePulse = 1'b1;
        mErrPulse  = 1'b1;
      end else begin
        mDrainAge = mDrainAge + 1;
      end
    end else begin
      mPhase     = SEQ_WAIT;
      mDonePulse = 1'b1;
    end
    if (conf_req) mPending = 1'b1;
    else if (taken) mPending = 1'b0;
    if (mDonePulse) doneQ.push_back(mErrPulse);
  endtask

  // Monitor: compares every cycle's outputs and each finished sequence's status.
  always @(negedge clk) begin
    if (monitorOn) begin
      if (snapQ.size() > 0) begin
        monSnap = snapQ.pop_front();
        checkOutput("up_ready", 32'(bus.up_ready), 32'(monSnap.upReady));
        checkOutput("dn_valid", 32'(bus.dn_valid), 32'(monSnap.dnValid));
        checkOutput("conf_valid", 32'(conf_valid), 32'(monSnap.confValid));
        checkOutput("conf_done", 32'(conf_done), 32'(monSnap.confDone));
        checkOutput("conf_err", 32'(conf_err), 32'(monSnap.confErr));
        checkOutput("conf_busy", 32'(conf_busy), 32'(monSnap.confBusy));
        checkOutput("underflow_err", 32'(underflow_err), 32'(monSnap.underflow));
        checkOutput("inflight", 32'(inflight), 32'(monSnap.inflight));
      end
      if (conf_done === 1'b1) begin
        if (doneQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL done_status: got unexpected conf_done expected none at %0t", $time);
        end else begin
          checkOutput("done_status_err", 32'(conf_err), 32'(doneQ.pop_front()));
        end
      end
    end
  end

  // Stimulus: reset, then randomized segments biased toward normal traffic,
  // drain timeouts, counter saturation and underflow.
  initial begin
    rstn          = 1'b0;
    conf_req      = 1'b0;
    bus.up_valid  = 1'b0;
    bus.dn_ready  = 1'b0;
    bus.her_valid = 1'b0;
    bus.her_ready = 1'b0;
    bus.fb_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    monitorOn = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      applyStimulus((cyc / 300) % 4);
      pushSnapshot();
      modelAdvance();
      @(posedge clk);
      #1;
    end
    conf_req      = 1'b0;
    bus.up_valid  = 1'b0;
    bus.her_valid = 1'b0;
    bus.fb_valid  = 1'b0;
    @(negedge clk);
    #1;
    monitorOn = 1'b0;
    checkOutput("done_queue_leftover", 32'(doneQ.size()), 32'd0);
    checkOutput("snap_queue_leftover", 32'(snapQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
